// File: rtl/dice_cgra_mesh.sv
`default_nettype none
// ============================================================================
// Module   : dice_tile / dice_cgra_mesh
// Purpose  : dice_cgra_mesh is a ROWS x COLS mesh of dice_tile cells with
//            N/E/S/W nearest-neighbour links and flattened edge buses. A
//            streamed loader fills a shadow configuration bank and commits it
//            atomically to the active bank that drives the tiles.
// Ports    : clk, rst (async, active high)
//            N/S_in_t, N/S_out_t : 2*COLS*DATA_W edge tokens, col c track k
//                                   at [(2c+k)*DATA_W +: DATA_W]
//            E/W_in_t, E/W_out_t : 2*ROWS*DATA_W edge tokens, row r track k
//            *_in_p, *_out_p     : edge predicate bits, index 2c+k / 2r+k
//            cfg_wr_valid/ready/data : configuration word stream
//            cfg_commit, cfg_abort   : single-cycle loader requests
//            cfg_loaded, cfg_active, cfg_err, cfg_word_cnt : loader status
// Option   : DICE_CGRA_EDGE_REG_EN registers every *_out_t / *_out_p edge bus.
// Revision : 1.0 - initial parametrised mesh with streamed loader
// ============================================================================

// Tile config layout (low bits of the tile config word):
//   [15:0]  data out selects, 2 bits per output o (N0,N1,E0,E1,S0,S1,W0,W1)
//           0 = zero, 1 = opposite side track 0, 2 = opposite track 1, 3 = ALU
//   [31:16] predicate out selects, same order, 3 selects the ALU flag
//   [34:32] ALU operand A input index, [37:35] operand B input index
//   [40:38] ALU op, [41] operand B from immediate, [73:42] immediate
// Outputs only route from the opposite side or the registered ALU, so the
// mesh has no combinational loops whatever configuration is loaded.
module dice_tile #(
  parameter int DATA_W     = 32,
  parameter int TILE_CFG_W = 156
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TILE_CFG_W-1:0] cfg,
  input  logic [2*DATA_W-1:0]   n_in_t,
  input  logic [2*DATA_W-1:0]   e_in_t,
  input  logic [2*DATA_W-1:0]   s_in_t,
  input  logic [2*DATA_W-1:0]   w_in_t,
  input  logic [1:0]            n_in_p,
  input  logic [1:0]            e_in_p,
  input  logic [1:0]            s_in_p,
  input  logic [1:0]            w_in_p,
  output logic [2*DATA_W-1:0]   n_out_t,
  output logic [2*DATA_W-1:0]   e_out_t,
  output logic [2*DATA_W-1:0]   s_out_t,
  output logic [2*DATA_W-1:0]   w_out_t,
  output logic [1:0]            n_out_p,
  output logic [1:0]            e_out_p,
  output logic [1:0]            s_out_p,
  output logic [1:0]            w_out_p
);
  logic [73:0]         cf;
  logic [8*DATA_W-1:0] in_all;
  logic [DATA_W-1:0]   op_a, op_b, alu_d, alu_q;
  logic                flag_d, flag_q;

  if (TILE_CFG_W >= 74) begin : g_cfg_trunc
    assign cf = cfg[73:0];
    if (TILE_CFG_W > 74) begin : g_cfg_rsvd
      logic rsvd_unused;
      assign rsvd_unused = ^cfg[TILE_CFG_W-1:74];
    end
  end else begin : g_cfg_pad
    assign cf = {{(74-TILE_CFG_W){1'b0}}, cfg};
  end

  function automatic logic [DATA_W-1:0] sel_t(input logic [1:0] sel,
      input logic [2*DATA_W-1:0] opp, input logic [DATA_W-1:0] alu);
    case (sel)
      2'd1:    return opp[0 +: DATA_W];
      2'd2:    return opp[DATA_W +: DATA_W];
      2'd3:    return alu;
      default: return '0;
    endcase
  endfunction

  function automatic logic sel_p(input logic [1:0] sel, input logic [1:0] opp,
      input logic flag);
    case (sel)
      2'd1:    return opp[0];
      2'd2:    return opp[1];
      2'd3:    return flag;
      default: return 1'b0;
    endcase
  endfunction

  assign n_out_t = {sel_t(cf[3:2],   s_in_t, alu_q), sel_t(cf[1:0],   s_in_t, alu_q)};
  assign e_out_t = {sel_t(cf[7:6],   w_in_t, alu_q), sel_t(cf[5:4],   w_in_t, alu_q)};
  assign s_out_t = {sel_t(cf[11:10], n_in_t, alu_q), sel_t(cf[9:8],   n_in_t, alu_q)};
  assign w_out_t = {sel_t(cf[15:14], e_in_t, alu_q), sel_t(cf[13:12], e_in_t, alu_q)};
  assign n_out_p = {sel_p(cf[19:18], s_in_p, flag_q), sel_p(cf[17:16], s_in_p, flag_q)};
  assign e_out_p = {sel_p(cf[23:22], w_in_p, flag_q), sel_p(cf[21:20], w_in_p, flag_q)};
  assign s_out_p = {sel_p(cf[27:26], n_in_p, flag_q), sel_p(cf[25:24], n_in_p, flag_q)};
  assign w_out_p = {sel_p(cf[31:30], e_in_p, flag_q), sel_p(cf[29:28], e_in_p, flag_q)};

  assign in_all = {w_in_t, s_in_t, e_in_t, n_in_t};

  always_comb begin
    op_a   = in_all[cf[34:32]*DATA_W +: DATA_W];
    op_b   = cf[41] ? DATA_W'(cf[73:42]) : in_all[cf[37:35]*DATA_W +: DATA_W];
    alu_d  = '0;
    flag_d = 1'b0;
    case (cf[40:38])
      3'd0:    alu_d = op_a + op_b;
      3'd1:    alu_d = op_a - op_b;
      3'd2:    alu_d = op_a & op_b;
      3'd3:    alu_d = op_a | op_b;
      3'd4:    alu_d = op_a ^ op_b;
      3'd5:    alu_d = op_a;
      3'd6:    alu_d = DATA_W'(op_a < op_b);
      default: alu_d = DATA_W'(op_a == op_b);
    endcase
    flag_d = |alu_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      flag_q <= flag_d;
    end
  end
endmodule

module dice_cgra_mesh #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_W     = 32,
  parameter int TILE_CFG_W = 156,
  parameter int CFG_WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*COLS*DATA_W-1:0] N_in_t,
  input  logic [2*COLS*DATA_W-1:0] S_in_t,
  output logic [2*COLS*DATA_W-1:0] N_out_t,
  output logic [2*COLS*DATA_W-1:0] S_out_t,
  input  logic [2*ROWS*DATA_W-1:0] E_in_t,
  input  logic [2*ROWS*DATA_W-1:0] W_in_t,
  output logic [2*ROWS*DATA_W-1:0] E_out_t,
  output logic [2*ROWS*DATA_W-1:0] W_out_t,
  input  logic [2*COLS-1:0]        N_in_p,
  input  logic [2*COLS-1:0]        S_in_p,
  output logic [2*COLS-1:0]        N_out_p,
  output logic [2*COLS-1:0]        S_out_p,
  input  logic [2*ROWS-1:0]        E_in_p,
  input  logic [2*ROWS-1:0]        W_in_p,
  output logic [2*ROWS-1:0]        E_out_p,
  output logic [2*ROWS-1:0]        W_out_p,
  input  logic                     cfg_wr_valid,
  output logic                     cfg_wr_ready,
  input  logic [CFG_WORD_W-1:0]    cfg_wr_data,
  input  logic                     cfg_commit,
  input  logic                     cfg_abort,
  output logic                     cfg_loaded,
  output logic                     cfg_active,
  output logic                     cfg_err,
  output logic [$clog2(ROWS*COLS*((TILE_CFG_W+CFG_WORD_W-1)/CFG_WORD_W)+1)-1:0] cfg_word_cnt
);
  localparam int WPT        = (TILE_CFG_W + CFG_WORD_W - 1) / CFG_WORD_W;
  localparam int NTILES     = ROWS * COLS;
  localparam int NWORDS     = NTILES * WPT;
  localparam int CNT_W      = $clog2(NWORDS + 1);
  localparam int TILE_PAD_W = WPT * CFG_WORD_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;
  state_t state;

  logic [NWORDS*CFG_WORD_W-1:0] shadow_cfg;
  logic [NTILES*TILE_CFG_W-1:0] shadow_tiles;
  logic [NTILES*TILE_CFG_W-1:0] active_cfg;
  logic [NTILES-1:0]            pad_unused;
  logic                         accept, last;

  // Shadow words are stored padded; each tile takes its low TILE_CFG_W bits.
  for (genvar t = 0; t < NTILES; t++) begin : g_unpack
    assign shadow_tiles[t*TILE_CFG_W +: TILE_CFG_W] = shadow_cfg[t*TILE_PAD_W +: TILE_CFG_W];
    if (TILE_PAD_W > TILE_CFG_W) begin : g_pad
      assign pad_unused[t] = ^shadow_cfg[t*TILE_PAD_W + TILE_CFG_W +: TILE_PAD_W - TILE_CFG_W];
    end else begin : g_nopad
      assign pad_unused[t] = 1'b0;
    end
  end

  assign cfg_wr_ready = (state != FULL);
  assign cfg_loaded   = (state == FULL);
  assign accept       = cfg_wr_valid && cfg_wr_ready;
  assign last         = (cfg_word_cnt == CNT_W'(NWORDS - 1));

  // Priority abort > commit > write. A commit that does not find the bank
  // FULL at the start of the cycle is ignored and flags cfg_err, while any
  // word presented alongside it is still accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      cfg_word_cnt <= '0;
      cfg_err      <= 1'b0;
      cfg_active   <= 1'b0;
      shadow_cfg   <= '0;
      active_cfg   <= '0;
    end else if (cfg_abort) begin
      state        <= EMPTY;
      cfg_word_cnt <= '0;
    end else if (cfg_commit && state == FULL) begin
      active_cfg   <= shadow_tiles;
      cfg_active   <= 1'b1;
      cfg_word_cnt <= '0;
      state        <= EMPTY;
    end else begin
      if (cfg_commit) begin
        cfg_err <= 1'b1;
      end else if (accept && state == EMPTY) begin
        cfg_err <= 1'b0;
      end
      if (accept) begin
        shadow_cfg[cfg_word_cnt*CFG_WORD_W +: CFG_WORD_W] <= cfg_wr_data;
        cfg_word_cnt <= cfg_word_cnt + 1'b1;
        state        <= last ? FULL : FILL;
      end
    end
  end

  // Mesh: links resolve to the neighbour's opposite-side output, or to the
  // edge bus on the boundary.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [2*DATA_W-1:0] n_in_t, e_in_t, s_in_t, w_in_t;
      logic [2*DATA_W-1:0] n_out_t, e_out_t, s_out_t, w_out_t;
      logic [1:0]          n_in_p, e_in_p, s_in_p, w_in_p;
      logic [1:0]          n_out_p, e_out_p, s_out_p, w_out_p;

      if (r == 0) begin : g_n_edge
        assign n_in_t = N_in_t[2*c*DATA_W +: 2*DATA_W];
        assign n_in_p = N_in_p[2*c +: 2];
      end else begin : g_n_link
        assign n_in_t = g_row[r-1].g_col[c].s_out_t;
        assign n_in_p = g_row[r-1].g_col[c].s_out_p;
      end
      if (r == ROWS-1) begin : g_s_edge
        assign s_in_t = S_in_t[2*c*DATA_W +: 2*DATA_W];
        assign s_in_p = S_in_p[2*c +: 2];
      end else begin : g_s_link
        assign s_in_t = g_row[r+1].g_col[c].n_out_t;
        assign s_in_p = g_row[r+1].g_col[c].n_out_p;
      end
      if (c == COLS-1) begin : g_e_edge
        assign e_in_t = E_in_t[2*r*DATA_W +: 2*DATA_W];
        assign e_in_p = E_in_p[2*r +: 2];
      end else begin : g_e_link
        assign e_in_t = g_row[r].g_col[c+1].w_out_t;
        assign e_in_p = g_row[r].g_col[c+1].w_out_p;
      end
      if (c == 0) begin : g_w_edge
        assign w_in_t = W_in_t[2*r*DATA_W +: 2*DATA_W];
        assign w_in_p = W_in_p[2*r +: 2];
      end else begin : g_w_link
        assign w_in_t = g_row[r].g_col[c-1].e_out_t;
        assign w_in_p = g_row[r].g_col[c-1].e_out_p;
      end

      dice_tile #(.DATA_W(DATA_W), .TILE_CFG_W(TILE_CFG_W)) u_tile (
        .clk(clk), .rst(rst),
        .cfg(active_cfg[(r*COLS+c)*TILE_CFG_W +: TILE_CFG_W]),
        .n_in_t(n_in_t), .e_in_t(e_in_t), .s_in_t(s_in_t), .w_in_t(w_in_t),
        .n_in_p(n_in_p), .e_in_p(e_in_p), .s_in_p(s_in_p), .w_in_p(w_in_p),
        .n_out_t(n_out_t), .e_out_t(e_out_t), .s_out_t(s_out_t), .w_out_t(w_out_t),
        .n_out_p(n_out_p), .e_out_p(e_out_p), .s_out_p(s_out_p), .w_out_p(w_out_p)
      );
    end
  end

  logic [2*COLS*DATA_W-1:0] edge_n_t, edge_s_t;
  logic [2*ROWS*DATA_W-1:0] edge_e_t, edge_w_t;
  logic [2*COLS-1:0]        edge_n_p, edge_s_p;
  logic [2*ROWS-1:0]        edge_e_p, edge_w_p;

  for (genvar c = 0; c < COLS; c++) begin : g_ns_edge
    assign edge_n_t[2*c*DATA_W +: 2*DATA_W] = g_row[0].g_col[c].n_out_t;
    assign edge_s_t[2*c*DATA_W +: 2*DATA_W] = g_row[ROWS-1].g_col[c].s_out_t;
    assign edge_n_p[2*c +: 2]               = g_row[0].g_col[c].n_out_p;
    assign edge_s_p[2*c +: 2]               = g_row[ROWS-1].g_col[c].s_out_p;
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_ew_edge
    assign edge_e_t[2*r*DATA_W +: 2*DATA_W] = g_row[r].g_col[COLS-1].e_out_t;
    assign edge_w_t[2*r*DATA_W +: 2*DATA_W] = g_row[r].g_col[0].w_out_t;
    assign edge_e_p[2*r +: 2]               = g_row[r].g_col[COLS-1].e_out_p;
    assign edge_w_p[2*r +: 2]               = g_row[r].g_col[0].w_out_p;
  end

`ifdef DICE_CGRA_EDGE_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      N_out_t <= '0; S_out_t <= '0; E_out_t <= '0; W_out_t <= '0;
      N_out_p <= '0; S_out_p <= '0; E_out_p <= '0; W_out_p <= '0;
    end else begin
      N_out_t <= edge_n_t; S_out_t <= edge_s_t; E_out_t <= edge_e_t; W_out_t <= edge_w_t;
      N_out_p <= edge_n_p; S_out_p <= edge_s_p; E_out_p <= edge_e_p; W_out_p <= edge_w_p;
    end
  end
`else
  assign N_out_t = edge_n_t;
  assign S_out_t = edge_s_t;
  assign E_out_t = edge_e_t;
  assign W_out_t = edge_w_t;
  assign N_out_p = edge_n_p;
  assign S_out_p = edge_s_p;
  assign E_out_p = edge_e_p;
  assign W_out_p = edge_w_p;
`endif
endmodule
`default_nettype wire
